replay_buffer_ctrl: RTL and testbench

- Parametrised transmit-side replay buffer for the link layer.
- Accepts outgoing TLP words, assigns each a sequence number, and stores each word until it is acknowledged.
- Forwards stored words to the transmitter; ACK purges acknowledged entries.
- NAK or replay-timer expiry rewinds transmission to the oldest unacknowledged entry. Repeated replays without forward progress raise a retrain request.

---
 rtl/replay_buffer_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_replay_buffer_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/replay_buffer_ctrl.sv
// Transmit-side replay buffer for the link layer.
// Words are stored until acknowledged; the sequence number of each word is
// implied by its distance from the head entry, so only the head sequence is
// kept in a register. Pointers carry one extra wrap bit so that a completely
// sent or completely full buffer is distinguishable from an empty one.
module replay_buffer_ctrl #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 64,
    parameter int SEQ_W       = 12,
    parameter int TIMEOUT_CYC = 1024,
    parameter int REPLAY_MAX  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [DATA_W-1:0]        tx_data,
    output logic [SEQ_W-1:0]         tx_seq,
    input  logic [1:0]               ack_nak,
    input  logic [SEQ_W-1:0]         ack_seq,
    output logic                     replaying,
    output logic                     retrain_req,
    output logic                     dllp_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int RC_W  = (REPLAY_MAX > 1) ? $clog2(REPLAY_MAX) : 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REPLAY = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [CNT_W-1:0]  head_r, send_r, tail_r, replay_end_r, count_r;
    logic [SEQ_W-1:0]  head_seq_r;
    logic [TMR_W-1:0]  timer_r;
    logic [RC_W-1:0]   rcnt_r;
    state_t            state_r;
    logic              retrain_r, dllp_err_r;

    logic [CNT_W-1:0]  sent_s, head_n, send_n, tail_n, replay_end_n;
    logic [SEQ_W-1:0]  d_s, head_seq_n;
    logic [TMR_W-1:0]  timer_n;
    logic [RC_W-1:0]   rcnt_n, rc_base_s;
    state_t            state_n;
    logic              write_s, tx_fire_s, ack_act_s, is_nak_s, in_range_s, dup_s;
    logic              progress_s, nak_ok_s, timeout_s, replay_start_s;
    logic              retrain_n, err_n;

    assign sent_s     = send_r - head_r;
    assign in_ready   = (count_r < CNT_W'(DEPTH));
    assign write_s    = in_valid && in_ready;
    assign tx_valid   = (send_r != tail_r);
    assign tx_fire_s  = tx_valid && tx_ready;
    assign tx_data    = mem_r[send_r[PTR_W-1:0]];
    assign tx_seq     = head_seq_r + SEQ_W'(sent_s);
    assign d_s        = ack_seq - head_seq_r;
    assign ack_act_s  = (ack_nak == 2'b01) || (ack_nak == 2'b10);
    assign is_nak_s   = (ack_nak == 2'b10);
    assign in_range_s = (d_s < SEQ_W'(sent_s));
    assign dup_s      = (ack_seq == (head_seq_r - SEQ_W'(1)));
    assign tail_n     = write_s ? (tail_r + CNT_W'(1)) : tail_r;
    assign replaying  = (state_r == ST_REPLAY);
    assign retrain_req = retrain_r;
    assign dllp_err   = dllp_err_r;
    assign count      = count_r;

    // Next-state logic: ACK/NAK purge, timeout, replay rewind and FSM.
    always_comb begin
        head_n         = head_r;
        head_seq_n     = head_seq_r;
        send_n         = send_r;
        replay_end_n   = replay_end_r;
        state_n        = state_r;
        timer_n        = timer_r;
        rcnt_n         = rcnt_r;
        rc_base_s      = rcnt_r;
        retrain_n      = 1'b0;
        err_n          = 1'b0;
        progress_s     = 1'b0;
        nak_ok_s       = 1'b0;
        timeout_s      = 1'b0;
        replay_start_s = 1'b0;

        if (tx_fire_s) begin
            send_n = send_r + CNT_W'(1);
        end else begin
            send_n = send_r;
        end

        // d < sent purges d+1 entries; ack_seq == head-1 is a harmless duplicate
        if (ack_act_s) begin
            if (in_range_s) begin
                head_n     = head_r + CNT_W'(d_s) + CNT_W'(1);
                head_seq_n = ack_seq + SEQ_W'(1);
                progress_s = 1'b1;
                nak_ok_s   = is_nak_s;
            end else if (dup_s) begin
                nak_ok_s   = is_nak_s;
            end else begin
                err_n      = 1'b1;
            end
        end else begin
            nak_ok_s = 1'b0;
        end

        // a purge in the same cycle as the timer hit wins over the timeout
        timeout_s      = (timer_r == TMR_W'(TIMEOUT_CYC - 1)) && (sent_s != {CNT_W{1'b0}})
                         && !progress_s;
        replay_start_s = (nak_ok_s || timeout_s) && (state_r == ST_IDLE);
        rc_base_s      = progress_s ? {RC_W{1'b0}} : rcnt_r;

        if (replay_start_s) begin
            // replay end includes a word taken by the transmitter this cycle
            replay_end_n = send_n;
            send_n       = head_n;
            state_n      = ST_REPLAY;
            if (rc_base_s == RC_W'(REPLAY_MAX - 1)) begin
                rcnt_n    = {RC_W{1'b0}};
                retrain_n = 1'b1;
            end else begin
                rcnt_n    = rc_base_s + RC_W'(1);
            end
        end else begin
            rcnt_n = rc_base_s;
            if (state_r == ST_REPLAY) begin
                // second term closes a replay that had nothing to resend
                if ((send_n == replay_end_r) || (send_r == replay_end_r)) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_REPLAY;
                end
            end else begin
                state_n = state_r;
            end
        end

        if (progress_s || replay_start_s || timeout_s) begin
            timer_n = {TMR_W{1'b0}};
        end else if (sent_s != {CNT_W{1'b0}}) begin
            timer_n = timer_r + TMR_W'(1);
        end else begin
            timer_n = {TMR_W{1'b0}};
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r       <= {CNT_W{1'b0}};
            send_r       <= {CNT_W{1'b0}};
            tail_r       <= {CNT_W{1'b0}};
            replay_end_r <= {CNT_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            head_seq_r   <= {SEQ_W{1'b0}};
            timer_r      <= {TMR_W{1'b0}};
            rcnt_r       <= {RC_W{1'b0}};
            state_r      <= ST_IDLE;
            retrain_r    <= 1'b0;
            dllp_err_r   <= 1'b0;
        end else begin
            head_r       <= head_n;
            send_r       <= send_n;
            tail_r       <= tail_n;
            replay_end_r <= replay_end_n;
            count_r      <= tail_n - head_n;
            head_seq_r   <= head_seq_n;
            timer_r      <= timer_n;
            rcnt_r       <= rcnt_n;
            state_r      <= state_n;
            retrain_r    <= retrain_n;
            dllp_err_r   <= err_n;
        end
    end

    // Data storage: contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[tail_r[PTR_W-1:0]] <= in_data;
        end
    end

endmodule

// File: tb/tb_replay_buffer_ctrl.sv
// Directed self-checking bench for replay_buffer_ctrl (DEPTH=4, TIMEOUT_CYC=16).
module tb_replay_buffer_ctrl;

    localparam int DW = 16;
    localparam int DP = 4;
    localparam int SW = 12;
    localparam int TO = 16;
    localparam int RM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          tx_valid;
    logic          tx_ready;
    logic [DW-1:0] tx_data;
    logic [SW-1:0] tx_seq;
    logic [1:0]    ack_nak;
    logic [SW-1:0] ack_seq;
    logic          replaying;
    logic          retrain_req;
    logic          dllp_err;
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;
    int n;
    int rt = 0;
    int s;

    replay_buffer_ctrl #(
        .DATA_W(DW), .DEPTH(DP), .SEQ_W(SW), .TIMEOUT_CYC(TO), .REPLAY_MAX(RM)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_seq(tx_seq),
        .ack_nak(ack_nak), .ack_seq(ack_seq),
        .replaying(replaying), .retrain_req(retrain_req), .dllp_err(dllp_err),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pull(input string tag, input logic [SW-1:0] es, input logic [DW-1:0] ed);
        check({tag, "_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_seq"}, 32'(tx_seq), 32'(es));
        check({tag, "_data"}, 32'(tx_data), 32'(ed));
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
    endtask

    task automatic acknak(input logic [1:0] t, input logic [SW-1:0] sq);
        ack_nak = t;
        ack_seq = sq;
        step();
        ack_nak = 2'b00;
    endtask

    task automatic wait_replay();
        n = 0;
        while (!replaying && n < 40) begin
            step();
            n++;
            if (retrain_req) rt++;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 16'h0000; tx_ready = 1'b0;
        ack_nak = 2'b00; ack_seq = 12'h000;
        step(); step();
        reset = 1'b0;
        check("rst_count", 32'(count), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_replaying", 32'(replaying), 32'd0);
        check("rst_retrain", 32'(retrain_req), 32'd0);
        check("rst_dllp_err", 32'(dllp_err), 32'd0);

        // basic flow
        push(16'hA001); push(16'hB002); push(16'hC003);
        check("basic_count3", 32'(count), 32'd3);
        pull("b0", 12'd0, 16'hA001);
        pull("b1", 12'd1, 16'hB002);
        pull("b2", 12'd2, 16'hC003);
        check("basic_tx_empty", 32'(tx_valid), 32'd0);
        acknak(2'b01, 12'd1);
        check("basic_ack1_count", 32'(count), 32'd1);
        check("basic_ack1_err", 32'(dllp_err), 32'd0);
        acknak(2'b01, 12'd2);
        check("basic_ack2_count", 32'(count), 32'd0);

        // full buffer: seq 3..6, fifth write refused
        push(16'hD000); push(16'hD001); push(16'hD002); push(16'hD003);
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        push(16'hEEEE);
        check("full_no_store", 32'(count), 32'd4);
        pull("f0", 12'd3, 16'hD000);
        pull("f1", 12'd4, 16'hD001);
        pull("f2", 12'd5, 16'hD002);
        pull("f3", 12'd6, 16'hD003);
        check("full_tx_empty", 32'(tx_valid), 32'd0);
        acknak(2'b01, 12'd6);
        check("full_ack_count", 32'(count), 32'd0);
        check("full_ack_ready", 32'(in_ready), 32'd1);

        // NAK replay: seq 7..10 sent, NAK 8 purges 7,8 and replays 9,10
        push(16'h1700); push(16'h1701); push(16'h1702); push(16'h1703);
        pull("n0", 12'd7, 16'h1700);
        pull("n1", 12'd8, 16'h1701);
        pull("n2", 12'd9, 16'h1702);
        pull("n3", 12'd10, 16'h1703);
        acknak(2'b10, 12'd8);
        check("nak_replaying", 32'(replaying), 32'd1);
        check("nak_count", 32'(count), 32'd2);
        pull("nr0", 12'd9, 16'h1702);
        check("nak_still_replay", 32'(replaying), 32'd1);
        pull("nr1", 12'd10, 16'h1703);
        check("nak_replay_done", 32'(replaying), 32'd0);
        check("nak_tx_empty", 32'(tx_valid), 32'd0);
        acknak(2'b01, 12'd10);
        check("nak_ack_count", 32'(count), 32'd0);

        // invalid / duplicate: head seq 11, sent 2
        push(16'h2B00); push(16'h2B01);
        pull("i0", 12'd11, 16'h2B00);
        pull("i1", 12'd12, 16'h2B01);
        acknak(2'b01, 12'd15);
        check("inv_err", 32'(dllp_err), 32'd1);
        check("inv_count", 32'(count), 32'd2);
        step();
        check("inv_err_pulse", 32'(dllp_err), 32'd0);
        acknak(2'b01, 12'd10);
        check("dup_err", 32'(dllp_err), 32'd0);
        check("dup_count", 32'(count), 32'd2);
        acknak(2'b10, 12'd10);
        check("dupnak_replay", 32'(replaying), 32'd1);
        check("dupnak_count", 32'(count), 32'd2);
        pull("ir0", 12'd11, 16'h2B00);
        pull("ir1", 12'd12, 16'h2B01);
        check("dupnak_done", 32'(replaying), 32'd0);
        acknak(2'b01, 12'd12);
        check("inv_final_count", 32'(count), 32'd0);

        // timeouts: seq 13 never acknowledged, fourth replay raises retrain
        push(16'h7000);
        pull("t0", 12'd13, 16'h7000);
        for (int k = 1; k <= RM; k++) begin
            wait_replay();
            check("to_latency", 32'(n), 32'd16);
            check("to_retrain_cnt", 32'(rt), (k == RM) ? 32'd1 : 32'd0);
            pull("to_resend", 12'd13, 16'h7000);
            check("to_end", 32'(replaying), 32'd0);
            check("to_retrain_pulse", 32'(retrain_req), 32'd0);
        end
        acknak(2'b01, 12'd13);
        check("to_ack_count", 32'(count), 32'd0);

        // advance sequence numbers to 4094 in batches of four
        s = 14;
        for (int b = 0; b < 1020; b++) begin
            repeat (4) push(16'h5555);
            tx_ready = 1'b1;
            repeat (4) step();
            tx_ready = 1'b0;
            acknak(2'b01, 12'(s + 3));
            s += 4;
        end
        check("wrap_pre_count", 32'(count), 32'd0);
        push(16'hB000); push(16'hB001); push(16'hB002);
        pull("w0", 12'd4094, 16'hB000);
        pull("w1", 12'd4095, 16'hB001);
        pull("w2", 12'd0, 16'hB002);
        acknak(2'b01, 12'd0);
        check("wrap_ack_count", 32'(count), 32'd0);
        check("wrap_ack_err", 32'(dllp_err), 32'd0);

        // reset during replay
        push(16'hC001); push(16'hC002);
        pull("r0", 12'd1, 16'hC001);
        pull("r1", 12'd2, 16'hC002);
        acknak(2'b10, 12'd1);
        check("rr_replaying", 32'(replaying), 32'd1);
        check("rr_seq", 32'(tx_seq), 32'd2);
        reset = 1'b1;
        step();
        check("rr_count", 32'(count), 32'd0);
        check("rr_tx_valid", 32'(tx_valid), 32'd0);
        check("rr_replay_off", 32'(replaying), 32'd0);
        check("rr_in_ready", 32'(in_ready), 32'd1);
        reset = 1'b0;
        push(16'hC0DE);
        check("rr_new_seq", 32'(tx_seq), 32'd0);
        check("rr_new_data", 32'(tx_data), 32'hC0DE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
